// File: rtl/mem_io_responder.sv
// Byte-wide memory responder: RAM with a registered read, plus an I/O window
// holding receive/transmit FIFOs, a free-running cycle counter and a stop flag.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int RX_DEPTH   = 4,
    parameter int TX_DEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        cpu_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW:0] TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};

    logic [7:0]     ram_r [0:(2**ADDR_WIDTH)-1];
    logic [7:0]     rx_mem_r [0:RX_DEPTH-1];
    logic [7:0]     tx_mem_r [0:TX_DEPTH-1];
    logic [RX_AW:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [TX_AW:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [31:0]    counter_r, snapshot_r;
    logic [7:0]     mem_din_r;
    logic           halted_r;

    logic       io_sel_s, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic       rx_rd_req_s, tx_req_s, accept_s;
    logic       rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
    logic [2:0] io_off_s;
    logic [7:0] rd_data_s, tx_push_data_s;
    logic       unused_s;

    assign unused_s = ^mem_a;
    assign io_sel_s = (mem_a[17:16] == 2'b11);
    assign io_off_s = mem_a[2:0];

    // Full when the wrap bits differ and the index bits agree
    assign rx_empty_s = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s  = (rx_wr_ptr_r[RX_AW] != rx_rd_ptr_r[RX_AW]) &&
                        (rx_wr_ptr_r[RX_AW-1:0] == rx_rd_ptr_r[RX_AW-1:0]);
    assign tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s  = (tx_wr_ptr_r[TX_AW] != tx_rd_ptr_r[TX_AW]) &&
                        (tx_wr_ptr_r[TX_AW-1:0] == tx_rd_ptr_r[TX_AW-1:0]);

    assign rx_rd_req_s = io_sel_s && !mem_wr && (io_off_s == 3'd0);
    assign tx_req_s    = io_sel_s && mem_wr && !halted_r &&
                         (((io_off_s == 3'd0) && (mem_dout != 8'h00)) || (io_off_s == 3'd4));

    // Stall the CPU when an I/O access has nowhere to go
    always_comb begin
        accept_s = 1'b1;
        if ((rx_rd_req_s && rx_empty_s) || (tx_req_s && tx_full_s)) begin
            accept_s = 1'b0;
        end else begin
            accept_s = 1'b1;
        end
    end

    assign cpu_rdy   = accept_s;
    assign rx_push_s = rx_valid && !rx_full_s;
    assign rx_pop_s  = accept_s && rx_rd_req_s;
    assign tx_push_s = accept_s && tx_req_s;
    assign tx_pop_s  = !tx_empty_s && tx_ready;

    // The stop register queues a zero byte as its end-of-program marker
    always_comb begin
        tx_push_data_s = mem_dout;
        if (io_off_s == 3'd4) begin
            tx_push_data_s = 8'h00;
        end else begin
            tx_push_data_s = mem_dout;
        end
    end

    // Read data selection for the access presented this cycle
    always_comb begin
        rd_data_s = 8'h00;
        if (!io_sel_s) begin
            rd_data_s = ram_r[mem_a[ADDR_WIDTH-1:0]];
        end else begin
            case (io_off_s)
                3'd0:    rd_data_s = rx_mem_r[rx_rd_ptr_r[RX_AW-1:0]];
                3'd4:    rd_data_s = counter_r[7:0];
                3'd5:    rd_data_s = snapshot_r[15:8];
                3'd6:    rd_data_s = snapshot_r[23:16];
                3'd7:    rd_data_s = snapshot_r[31:24];
                default: rd_data_s = 8'h00;
            endcase
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (accept_s && mem_wr && !io_sel_s) begin
            ram_r[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        end
    end

    // FIFO storage; stale entries are never visible because of the empty gating
    always_ff @(posedge clk_in) begin
        if (rx_push_s) begin
            rx_mem_r[rx_wr_ptr_r[RX_AW-1:0]] <= rx_data;
        end
        if (tx_push_s) begin
            tx_mem_r[tx_wr_ptr_r[TX_AW-1:0]] <= tx_push_data_s;
        end
    end

    // Control state: read register, counter, snapshot, halt flag, FIFO pointers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mem_din_r   <= 8'h00;
            counter_r   <= 32'h0000_0000;
            snapshot_r  <= 32'h0000_0000;
            halted_r    <= 1'b0;
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
        end else begin
            counter_r <= counter_r + 32'd1;
            if (accept_s && !mem_wr) begin
                mem_din_r <= rd_data_s;
                if (io_sel_s && (io_off_s == 3'd4)) begin
                    snapshot_r <= counter_r;
                end
            end
            if (tx_push_s && (io_off_s == 3'd4)) begin
                halted_r <= 1'b1;
            end
            if (rx_push_s) begin
                rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE;
            end
            if (tx_push_s) begin
                tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE;
            end
        end
    end

    // Transmit head is shown as zero while the queue is empty
    always_comb begin
        tx_data = 8'h00;
        if (tx_empty_s) begin
            tx_data = 8'h00;
        end else begin
            tx_data = tx_mem_r[tx_rd_ptr_r[TX_AW-1:0]];
        end
    end

    assign tx_valid = !tx_empty_s;
    assign rx_ready = !rx_full_s;
    assign mem_din  = mem_din_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, both FIFOs, counter snapshot,
// halt behaviour and asynchronous reset in the middle of traffic.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        cpu_rdy;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halted;

    int          n_tests = 0;
    int          n_fail = 0;
    logic        last_rdy;
    logic [31:0] cyc;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .cpu_rdy(cpu_rdy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halted(halted)
    );

    always #5 clk_in = ~clk_in;

    // Expected value of the DUT cycle counter: cycles since reset release
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) cyc <= 32'h0;
        else         cyc <= cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle, driven just after a falling edge; cpu_rdy captured mid-cycle
    task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic rv, input logic [7:0] rd);
        mem_a = a; mem_wr = w; mem_dout = d; rx_valid = rv; rx_data = rd;
        #1;
        last_rdy = cpu_rdy;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    task automatic idle();
        step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        #1;
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_halted", halted, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;

        // RAM: write then read-back next cycle, address wrap above ADDR_WIDTH
        step(32'h0_0010, 1'b1, 8'hA5, 1'b0, 8'h00);
        check("ram_wr_rdy", last_rdy, 1'b1);
        step(32'h0_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        check("ram_rd_a5", mem_din, 8'hA5);
        step(32'h2_0010, 1'b1, 8'h3C, 1'b0, 8'h00);
        step(32'h0_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        check("ram_wrap_3c", mem_din, 8'h3C);
        step(32'h0_0011, 1'b1, 8'h5A, 1'b0, 8'h00);
        step(32'h0_0011, 1'b0, 8'h00, 1'b0, 8'h00);
        check("ram_rd_5a", mem_din, 8'h5A);
        step(32'h0_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        check("ram_rd_3c", mem_din, 8'h3C);

        // Receive FIFO: empty stall, push does not bypass, then pop
        step(32'h3_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        check("rx_empty_rdy", last_rdy, 1'b0);
        check("rx_empty_hold", mem_din, 8'h3C);
        step(32'h3_0000, 1'b0, 8'h00, 1'b1, 8'h41);
        check("rx_push_rdy", last_rdy, 1'b0);
        check("rx_push_hold", mem_din, 8'h3C);
        step(32'h3_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        check("rx_pop_rdy", last_rdy, 1'b1);
        check("rx_pop_41", mem_din, 8'h41);
        step(32'h3_0001, 1'b0, 8'h00, 1'b0, 8'h00);
        check("io_other_rd", mem_din, 8'h00);

        // Receive FIFO fill past capacity, then drain in order (pointers wrap)
        for (int i = 0; i < 5; i++) begin
            step(32'h0, 1'b0, 8'h00, 1'b1, 8'h10 + 8'(i));
            if (i == 2) check("rx_ready_3", rx_ready, 1'b1);
            if (i == 3) check("rx_ready_full", rx_ready, 1'b0);
        end
        check("rx_ready_still_full", rx_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(32'h3_0000, 1'b0, 8'h00, 1'b0, 8'h00);
            check("rx_drain_rdy", last_rdy, 1'b1);
            check("rx_drain_data", mem_din, 32'h10 + 32'(i));
        end
        step(32'h3_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        check("rx_drained_rdy", last_rdy, 1'b0);
        check("rx_drained_hold", mem_din, 8'h13);

        // Transmit FIFO: zero byte ignored, fill, full stall, release on pop
        step(32'h3_0000, 1'b1, 8'h48, 1'b0, 8'h00);
        step(32'h3_0000, 1'b1, 8'h00, 1'b0, 8'h00);
        check("tx_zero_rdy", last_rdy, 1'b1);
        step(32'h3_0000, 1'b1, 8'h49, 1'b0, 8'h00);
        check("tx_head_valid", tx_valid, 1'b1);
        check("tx_head_48", tx_data, 8'h48);
        step(32'h3_0000, 1'b1, 8'h4A, 1'b0, 8'h00);
        step(32'h3_0000, 1'b1, 8'h4B, 1'b0, 8'h00);
        check("tx_fourth_rdy", last_rdy, 1'b1);
        step(32'h3_0000, 1'b1, 8'h4C, 1'b0, 8'h00);
        check("tx_full_rdy", last_rdy, 1'b0);
        step(32'h3_0000, 1'b1, 8'h4C, 1'b0, 8'h00);
        check("tx_full_rdy2", last_rdy, 1'b0);
        tx_ready = 1'b1;
        step(32'h3_0000, 1'b1, 8'h4C, 1'b0, 8'h00);
        check("tx_full_pop_rdy", last_rdy, 1'b0);
        tx_ready = 1'b0;
        step(32'h3_0000, 1'b1, 8'h4C, 1'b0, 8'h00);
        check("tx_after_pop_rdy", last_rdy, 1'b1);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tx_sink_valid", tx_valid, 1'b1);
            check("tx_sink_data", tx_data, 32'h49 + 32'(i));
            idle();
        end
        check("tx_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Asynchronous reset with both FIFOs holding data
        step(32'h0, 1'b0, 8'h00, 1'b1, 8'h61);
        step(32'h0, 1'b0, 8'h00, 1'b1, 8'h62);
        step(32'h3_0000, 1'b1, 8'h71, 1'b0, 8'h00);
        step(32'h3_0000, 1'b1, 8'h72, 1'b0, 8'h00);
        step(32'h0_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        check("pre_rst_tx_valid", tx_valid, 1'b1);
        check("pre_rst_mem_din", mem_din, 8'h3C);
        #2 rst_in = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_rx_ready", rx_ready, 1'b1);
        check("mid_rst_mem_din", mem_din, 8'h00);
        check("mid_rst_halted", halted, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Counter restarts from zero, then snapshot at 0x000102FF
        step(32'h3_0004, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_restart_0", mem_din, 8'h00);
        step(32'h3_0004, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_restart_1", mem_din, 8'h01);
        for (int g = 0; g < 70000 && cyc != 32'h0001_02FF; g++) idle();
        check("cnt_reach", cyc, 32'h0001_02FF);
        step(32'h3_0004, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_b0", mem_din, 8'hFF);
        step(32'h3_0005, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_b1", mem_din, 8'h02);
        step(32'h3_0006, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_b2", mem_din, 8'h01);
        step(32'h3_0007, 1'b0, 8'h00, 1'b0, 8'h00);
        check("cnt_b3", mem_din, 8'h00);
        step(32'h3_0000, 1'b0, 8'h00, 1'b0, 8'h00);
        check("post_rst_rx_empty", last_rdy, 1'b0);

        // Halt: zero byte queued, flag sticky, later I/O writes ignored
        step(32'h3_0004, 1'b1, 8'h77, 1'b0, 8'h00);
        check("halt_rdy", last_rdy, 1'b1);
        check("halt_flag", halted, 1'b1);
        check("halt_tx_valid", tx_valid, 1'b1);
        check("halt_tx_data", tx_data, 8'h00);
        tx_ready = 1'b1;
        idle();
        tx_ready = 1'b0;
        check("halt_tx_drained", tx_valid, 1'b0);
        step(32'h3_0000, 1'b1, 8'h55, 1'b0, 8'h00);
        check("halt_wr_rdy", last_rdy, 1'b1);
        check("halt_wr_dropped", tx_valid, 1'b0);
        step(32'h0_0010, 1'b0, 8'h00, 1'b0, 8'h00);
        check("halt_ram_rd", mem_din, 8'h3C);
        check("halt_sticky", halted, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Memory-side responder for the CPU's byte-wide bus (address, write strobe, data out, data in). It serves 2^ADDR_WIDTH bytes of RAM with a one-cycle registered read and a zero-wait write. It also decodes the I/O window at mem_a[17:16]==2'b11: a UART-style receive FIFO and transmit FIFO at 0x30000, and a cycle counter and program-stop register at 0x30004. It drives cpu_rdy low to pause the CPU whenever an I/O access cannot complete.

Parameters:
ADDR_WIDTH, 17, RAM byte-address width (128 KB); RAM addresses use mem_a[ADDR_WIDTH-1:0], upper bits ignored (wrap).
RX_DEPTH, 4, receive FIFO entries, power of two, >=2.
TX_DEPTH, 4, transmit FIFO entries, power of two, >=2.

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous reset, active-low
mem_a  input  32  CPU byte address
mem_wr  input  1  1 = write, 0 = read
mem_dout  input  8  CPU write data
mem_din  output  8  read data to CPU, registered
cpu_rdy  output  1  combinational; 0 = request not accepted this cycle, CPU must hold it
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  = receive FIFO not full
tx_data  output  8  head of transmit FIFO
tx_valid  output  1  = transmit FIFO not empty
tx_ready  input  1  sink accepts tx_data when tx_valid & tx_ready
halted  output  1  sticky, set by a write to 0x30004

Behaviour:
- Reset (rst_in=0, async): mem_din=0x00, FIFOs empty (rx_ready=1, tx_valid=0, tx_data=0x00), counter=0, snapshot=0, halted=0. RAM contents are not reset.
- An access is "I/O" when mem_a[17:16]==2'b11, otherwise it is "RAM". Every cycle with cpu_rdy=1 is one accepted access; there is no idle encoding, and reads are side-effect free except the 0x30000 pop and the 0x30004 snapshot.
- RAM read accepted in cycle N -> mem_din = ram[a] from cycle N+1 until the next accepted read.
- RAM write: ram[a] <= mem_dout at the edge ending cycle N. A read of the same address in cycle N+1 returns the new byte.
- cpu_rdy=0 exactly when either:
  - the access is an I/O read at 0x30000 and the receive FIFO is empty; or
  - the access is an I/O write to 0x30000 (nonzero data) or 0x30004, halted=0, and the transmit FIFO is full.
  In all other cases cpu_rdy=1. A non-accepted access causes no state change and mem_din holds its value.
- I/O reads (decoded on mem_a[2:0]):
  - 0x30000 pops the receive FIFO; the byte appears on mem_din in N+1.
  - 0x30004 returns counter[7:0] and latches snapshot <= counter.
  - 0x30005, 0x30006, 0x30007 return snapshot[15:8], [23:16], [31:24].
  - Any other I/O address reads 0x00.
- I/O writes:
  - 0x30000 with data!=0 pushes the byte to the transmit FIFO.
  - 0x30000 with data==0 is ignored and always accepted.
  - 0x30004 pushes 0x00 to the transmit FIFO and sets halted. Once halted=1, all I/O writes are ignored and accepted.
  - Other I/O addresses: writes are ignored.
- Counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF -> 0. It is not stopped by halted.
- Receive FIFO:
  - Push when rx_valid & rx_ready.
  - Simultaneous push and pop is legal when not empty; occupancy is unchanged.
  - A push into an empty FIFO does not satisfy a pop in the same cycle; that read stalls one cycle.
  - rx_ready depends only on the full flag (a pop in the same cycle does not free a slot).
- Transmit FIFO:
  - Pop when tx_valid & tx_ready.
  - The full test uses current occupancy only (no pop-and-push bypass when full).
  - Simultaneous push and pop is legal when not full.
  - tx_data and tx_valid are registered or derived from the head pointer; no combinational path from mem_dout.
- Pointers are log2(DEPTH)+1 bits; full and empty are decided by comparing the MSB and the remaining bits. Wrap-around must be exercised.

Test Plan:
- RAM: write 0xA5 to 0x00010 in cycle 0, read 0x00010 in cycle 1 -> mem_din=0xA5 in cycle 2. Write 0x3C to 0x20010 -> a read of 0x00010 returns 0x3C (wrap).
- Receive FIFO: read 0x30000 with the FIFO empty -> cpu_rdy=0 and mem_din held. Push 0x41 on rx -> next cycle cpu_rdy=1, and mem_din=0x41 the cycle after. Push RX_DEPTH+1 bytes with no reads -> rx_ready=0 after RX_DEPTH pushes, and bytes pop out in order.
- Transmit FIFO: write 0x48, 0x00, 0x49 to 0x30000 with tx_ready=0 -> exactly two entries queued. Fill the FIFO to TX_DEPTH, then write once more -> cpu_rdy=0 until one cycle after tx_ready=1 pops an entry. Sink receives bytes in order.
- Counter: read 0x30004 at counter=0x000102FF, then 0x30005, 0x30006, 0x30007 -> bytes 0xFF, 0x02, 0x01, 0x00, unchanged by the counter advancing between reads.
- Halt: write 0x30004 -> tx receives 0x00 and halted=1. A later write of 0x55 to 0x30000 is accepted but not queued. RAM reads still return data.
- Reset mid-operation: assert rst_in low between edges with both FIFOs half full -> immediately tx_valid=0, rx_ready=1, mem_din=0x00, halted=0. After release the counter restarts from 0.
